// File: rtl/irb_pkg.sv
// Purpose: shared op codes, FSM states and per-op address/length tables for the DMA engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package irb_pkg;

  typedef enum logic [2:0] {
    OP_INF = 3'd0,
    OP_FMI = 3'd1,
    OP_KEX = 3'd2,
    OP_KPW = 3'd3,
    OP_KDW = 3'd4,
    OP_FMO = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    WAIT_RD = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Indexed by op code; entries 7 and 6 are the illegal ops and stay zero.
  localparam logic [7:0][31:0] OP_BASE = {
    32'h0000_0000, 32'h0000_0000,
    32'h0000_5000, 32'h0000_4000, 32'h0000_3000,
    32'h0000_2000, 32'h0000_1000, 32'h0000_0000
  };

  localparam logic [7:0][15:0] OP_WORDS = {
    16'd0, 16'd0,
    16'd32, 16'd9, 16'd16,
    16'd32, 16'd64, 16'd2
  };

  // Transfer descriptor captured when a start pulse is accepted.
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] base;
    logic [15:0] words;
  } desc_t;

  function automatic logic op_is_read(input logic [2:0] op);
    return op <= OP_KDW;
  endfunction

endpackage

// File: rtl/dma_engine.sv
// Purpose: moves fixed-length word blocks between external memory and on-chip buffers / the layer config register.
// Latency: all outputs registered; each word raises ext_req one cycle after entering ISSUE, f_dma pulses the cycle after DONE.
// Backpressure: one external transaction outstanding; ext_req holds until ext_gnt, reads stall in WAIT_RD until ext_rvalid.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   s_dma, dma_op, dma_info1/2,
//   dma_mem_info1/2                - start pulse, op code and descriptors from the controller
//   f_dma                          - one-cycle done pulse
//   op_err                         - sticky flag, set by an illegal op (6/7), cleared only by rst
//   inf_conv                       - 64-bit layer configuration register (op INF)
//   ext_req/we/addr/wdata,
//   ext_gnt/rvalid/rdata           - external memory request/grant, read return
//   buf_sel/we/addr/wdata/rdata    - on-chip buffer port, buf_rdata valid one cycle after buf_addr
module dma_engine
  import irb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_dma,
  input  logic [2:0]  dma_op,
  input  logic [31:0] dma_info1,
  input  logic [31:0] dma_info2,
  input  logic [31:0] dma_mem_info1,
  input  logic [31:0] dma_mem_info2,
  output logic        f_dma,
  output logic        op_err,
  output logic [63:0] inf_conv,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_gnt,
  input  logic        ext_rvalid,
  input  logic [31:0] ext_rdata,
  output logic [2:0]  buf_sel,
  output logic        buf_we,
  output logic [15:0] buf_addr,
  output logic [31:0] buf_wdata,
  input  logic [31:0] buf_rdata
);

  state_e      state, state_nxt;
  desc_t       desc;
  logic [15:0] cnt, cnt_nxt;
  logic        is_write;
  logic        last;
  logic        gnt_ok;
  logic        rd_done;
  logic        start;

  // This engine derives everything from op and mem_info; the extra descriptor words are not needed.
  logic        info_unused;
  assign info_unused = ^{dma_info1, dma_info2};

  assign is_write = (desc.op == OP_FMO);
  assign last     = ((cnt + 16'd1) == desc.words);
  // A grant only counts once the request is actually on the wire.
  assign gnt_ok   = (state == ISSUE) && ext_req && ext_gnt;
  assign rd_done  = (state == WAIT_RD) && ext_rvalid;
  assign start    = (state == IDLE) && s_dma;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (s_dma) begin
          cnt_nxt = '0;
          if (dma_op == OP_FMO)       state_nxt = FETCH;
          else if (op_is_read(dma_op)) state_nxt = ISSUE;
          else                         state_nxt = DONE;
        end
      end
      FETCH: state_nxt = ISSUE;
      ISSUE: begin
        if (gnt_ok) begin
          if (is_write) begin
            cnt_nxt   = cnt + 16'd1;
            state_nxt = last ? DONE : FETCH;
          end else begin
            state_nxt = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (ext_rvalid) begin
          cnt_nxt   = cnt + 16'd1;
          state_nxt = last ? DONE : ISSUE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      desc      <= '0;
      cnt       <= '0;
      f_dma     <= 1'b0;
      op_err    <= 1'b0;
      inf_conv  <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      buf_sel   <= '0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else begin
      cnt    <= cnt_nxt;
      f_dma  <= (state == DONE);
      buf_we <= 1'b0;

      if (start) begin
        desc.op    <= dma_op;
        desc.base  <= OP_BASE[dma_op] + dma_mem_info1 + dma_mem_info2;
        desc.words <= OP_WORDS[dma_op];
        if (!op_is_read(dma_op) && (dma_op != OP_FMO)) begin
          op_err <= 1'b1;
        end
      end

      // Buffer address is loaded on entry so it is stable for the whole FETCH cycle;
      // the word then shows up on buf_rdata during the first ISSUE cycle.
      if (state_nxt == FETCH) begin
        buf_sel  <= OP_FMO;
        buf_addr <= cnt_nxt;
      end

      // First ISSUE cycle is a setup cycle: capture the fetched word, then raise the request.
      if (state == ISSUE) begin
        if (gnt_ok) begin
          ext_req <= 1'b0;
          ext_we  <= 1'b0;
        end else if (!ext_req) begin
          ext_req  <= 1'b1;
          ext_we   <= is_write;
          ext_addr <= desc.base + {16'h0000, cnt};
          if (is_write) begin
            ext_wdata <= buf_rdata;
          end
        end
      end

      if (rd_done) begin
        if (desc.op == OP_INF) begin
          if (cnt[0]) inf_conv[63:32] <= ext_rdata;
          else        inf_conv[31:0]  <= ext_rdata;
        end else begin
          buf_we    <= 1'b1;
          buf_sel   <= desc.op;
          buf_addr  <= cnt;
          buf_wdata <= ext_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_dma;
  logic [2:0]  dma_op;
  logic [31:0] dma_info1, dma_info2, dma_mem_info1, dma_mem_info2;
  logic        f_dma, op_err;
  logic [63:0] inf_conv;
  logic        ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [2:0]  buf_sel;
  logic        buf_we;
  logic [15:0] buf_addr;
  logic [31:0] buf_wdata, buf_rdata;

  always #5 clk = ~clk;

  dma_engine dut (
    .clk(clk), .rst(rst), .s_dma(s_dma), .dma_op(dma_op),
    .dma_info1(dma_info1), .dma_info2(dma_info2),
    .dma_mem_info1(dma_mem_info1), .dma_mem_info2(dma_mem_info2),
    .f_dma(f_dma), .op_err(op_err), .inf_conv(inf_conv),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .buf_sel(buf_sel), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [31:0] rdata; } hs_t;
  typedef struct { logic [2:0] sel; logic [15:0] addr; logic [31:0] data; } bw_t;

  hs_t         hs_q[$];
  bw_t         bw_q[$];
  logic [31:0] ovr_q[$];
  int          tests = 0, fails = 0;
  int          cyc = 0, start_cyc = 0;
  int          f_cnt = 0, f_cyc = -1, req_cycles = 0;
  int          gnt_delay = 0, gnt_wait = 0, rd_lat = 0;
  bit          rd_pend = 0, stray_en = 0, rand_gnt = 0;
  logic [31:0] rd_dat = '0, buf_base = 32'h100;
  logic [15:0] baddr_prev = '0;
  logic [2:0]  bsel_prev = '0;

  // Reference tables written straight from the op definitions.
  function automatic logic [31:0] ref_base(input logic [2:0] op);
    case (op)
      3'd0: return 32'h0;
      3'd1: return 32'h1000;
      3'd2: return 32'h2000;
      3'd3: return 32'h3000;
      3'd4: return 32'h4000;
      3'd5: return 32'h5000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_words(input logic [2:0] op);
    case (op)
      3'd0: return 2;
      3'd1: return 64;
      3'd2: return 32;
      3'd3: return 16;
      3'd4: return 9;
      3'd5: return 32;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  always @(posedge clk) cyc++;

  // Memory/buffer models and monitors, evaluated mid-cycle.
  always @(negedge clk) begin
    buf_rdata  = (bsel_prev == 3'd5) ? buf_base + {16'h0, baddr_prev} : (32'hBAD0_0000 | {16'h0, baddr_prev});
    baddr_prev = buf_addr;
    bsel_prev  = buf_sel;
    if (buf_we) bw_q.push_back('{buf_sel, buf_addr, buf_wdata});
    if (f_dma) begin
      f_cnt++;
      if (f_cyc < 0) f_cyc = cyc;
    end
    if (ext_req) req_cycles++;

    ext_rvalid = 1'b0;
    ext_rdata  = 32'hDEAD_BEEF;
    if (rst) begin
      rd_pend  = 0;
      gnt_wait = 0;
    end else if (rd_pend) begin
      if (rd_lat == 0) begin
        ext_rvalid = 1'b1;
        ext_rdata  = rd_dat;
        rd_pend    = 0;
      end else begin
        rd_lat--;
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      ext_rvalid = 1'b1;
    end

    ext_gnt = 1'b0;
    if (ext_req && !rst) begin
      if (gnt_wait >= gnt_delay) begin
        ext_gnt  = 1'b1;
        gnt_wait = 0;
        rd_dat   = (ovr_q.size() > 0) ? ovr_q.pop_front() : mem_val(ext_addr);
        hs_q.push_back('{ext_addr, ext_we, ext_wdata, rd_dat});
        if (!ext_we) begin
          rd_pend = 1;
          rd_lat  = $urandom_range(0, 2);
        end
        if (rand_gnt) gnt_delay = $urandom_range(0, 3);
      end else begin
        gnt_wait++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] op, input logic [31:0] m1, input logic [31:0] m2);
    hs_q.delete();
    bw_q.delete();
    f_cnt = 0; f_cyc = -1; req_cycles = 0;
    dma_op = op; dma_mem_info1 = m1; dma_mem_info2 = m2;
    dma_info1 = $urandom; dma_info2 = $urandom;
    s_dma = 1'b1;
    start_cyc = cyc;
    step();
    s_dma = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (f_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, ".done_in_time"}, 64'(f_cnt != 0), 64'd1);
    step(4);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".f_dma"},     64'(f_dma),     64'd0);
    chk({tag, ".ext_req"},   64'(ext_req),   64'd0);
    chk({tag, ".ext_we"},    64'(ext_we),    64'd0);
    chk({tag, ".ext_addr"},  64'(ext_addr),  64'd0);
    chk({tag, ".ext_wdata"}, 64'(ext_wdata), 64'd0);
    chk({tag, ".buf_we"},    64'(buf_we),    64'd0);
    chk({tag, ".buf_sel"},   64'(buf_sel),   64'd0);
    chk({tag, ".buf_addr"},  64'(buf_addr),  64'd0);
    chk({tag, ".buf_wdata"}, 64'(buf_wdata), 64'd0);
    chk({tag, ".inf_conv"},  inf_conv,       64'd0);
    chk({tag, ".op_err"},    64'(op_err),    64'd0);
  endtask

  // Compares everything observed during one transfer against the expected transaction list.
  task automatic verify(input string tag, input logic [2:0] op, input logic [31:0] m1,
                        input logic [31:0] m2, input logic [31:0] bb);
    logic [31:0] base;
    int          words;
    base  = ref_base(op) + m1 + m2;
    words = ref_words(op);
    chk({tag, ".f_pulses"}, 64'(f_cnt), 64'd1);
    chk({tag, ".n_ext"}, 64'(hs_q.size()), 64'(words));
    for (int i = 0; i < words && i < hs_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 64'(hs_q[i].addr), 64'(base + 32'(i)));
      chk($sformatf("%s.we%0d", tag, i), 64'(hs_q[i].we), 64'(op == 3'd5));
      if (op == 3'd5) chk($sformatf("%s.wdata%0d", tag, i), 64'(hs_q[i].wdata), 64'(bb + 32'(i)));
    end
    if (op >= 3'd1 && op <= 3'd4) begin
      chk({tag, ".n_buf_we"}, 64'(bw_q.size()), 64'(words));
      for (int i = 0; i < words && i < bw_q.size() && i < hs_q.size(); i++) begin
        chk($sformatf("%s.bsel%0d", tag, i), 64'(bw_q[i].sel), 64'(op));
        chk($sformatf("%s.baddr%0d", tag, i), 64'(bw_q[i].addr), 64'(i));
        chk($sformatf("%s.bdata%0d", tag, i), 64'(bw_q[i].data), 64'(hs_q[i].rdata));
      end
    end else begin
      chk({tag, ".n_buf_we"}, 64'(bw_q.size()), 64'd0);
    end
    if (op == 3'd0 && hs_q.size() == 2) chk({tag, ".inf_conv"}, inf_conv, {hs_q[1].rdata, hs_q[0].rdata});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] m1, m2;
    int          n;

    rst = 1'b1; s_dma = 1'b0; dma_op = '0;
    dma_info1 = '0; dma_info2 = '0; dma_mem_info1 = '0; dma_mem_info2 = '0;
    step(3);
    check_zero("reset");
    rst = 1'b0;
    step(2);

    // INF: two reads land in the configuration register.
    ovr_q.push_back(32'h1111_1111);
    ovr_q.push_back(32'h2222_2222);
    start(3'd0, 32'h0, 32'h0);
    wait_done("inf", 200);
    verify("inf", 3'd0, 32'h0, 32'h0, buf_base);
    chk("inf.value", inf_conv, 64'h2222_2222_1111_1111);

    // KDW with every grant held off three cycles.
    gnt_delay = 3;
    start(3'd4, 32'h10, 32'h2);
    wait_done("kdw", 500);
    verify("kdw", 3'd4, 32'h10, 32'h2, buf_base);
    chk("kdw.first_addr", (hs_q.size() > 0) ? 64'(hs_q[0].addr) : 64'hX, 64'h4012);

    // FMO: buffer word i holds 0x100+i.
    gnt_delay = 0;
    buf_base  = 32'h100;
    start(3'd5, 32'h0, 32'h0);
    wait_done("fmo", 800);
    verify("fmo", 3'd5, 32'h0, 32'h0, 32'h100);

    // KEX with start pulses and descriptor churn while busy, plus stray read returns.
    stray_en = 1; rand_gnt = 1;
    m1 = $urandom; m2 = $urandom;
    start(3'd2, m1, m2);
    for (int i = 0; i < 40; i++) begin
      s_dma = 1'($urandom_range(0, 1));
      dma_op = 3'($urandom_range(5, 7));
      dma_mem_info1 = $urandom;
      dma_mem_info2 = $urandom;
      step();
    end
    s_dma = 1'b0;
    wait_done("kex", 1500);
    verify("kex", 3'd2, m1, m2, buf_base);
    chk("kex.op_err", 64'(op_err), 64'd0);

    // FMI aborted by reset after the fifth word, then rerun to completion.
    m1 = $urandom; m2 = $urandom;
    start(3'd1, m1, m2);
    n = 0;
    while (bw_q.size() < 5 && n < 2000) begin
      step();
      n++;
    end
    chk("abort.reached_5", 64'(bw_q.size() >= 5), 64'd1);
    rst = 1'b1;
    step();
    check_zero("abort");
    rst = 1'b0;
    step(20);
    chk("abort.no_f_dma", 64'(f_cnt), 64'd0);
    start(3'd1, m1, m2);
    wait_done("fmi", 3000);
    verify("fmi", 3'd1, m1, m2, buf_base);

    // Illegal op; a start pulse in the DONE cycle must not launch anything.
    start(3'd7, $urandom, $urandom);
    dma_op = 3'd5;
    s_dma  = 1'b1;
    step();
    s_dma  = 1'b0;
    wait_done("bad", 50);
    step(10);
    chk("bad.f_latency", 64'(f_cyc - start_cyc), 64'd2);
    chk("bad.f_pulses", 64'(f_cnt), 64'd1);
    chk("bad.no_req", 64'(req_cycles), 64'd0);
    chk("bad.op_err", 64'(op_err), 64'd1);

    // Random legal ops, random descriptors and handshake timing.
    for (int t = 0; t < 6; t++) begin
      op = 3'($urandom_range(0, 5));
      m1 = $urandom; m2 = $urandom;
      buf_base = $urandom;
      start(op, m1, m2);
      wait_done($sformatf("rnd%0d", t), 3000);
      verify($sformatf("rnd%0d", t), op, m1, m2, buf_base);
    end
    chk("sticky.op_err", 64'(op_err), 64'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("final.op_err", 64'(op_err), 64'd0);
    chk("final.inf_conv", inf_conv, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
